// File: rtl/ulaplus_ext_if.sv
// CPU I/O bus as seen by the ULA+ controller: decode inputs plus read-data return path.
interface ulaplus_ext_if;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_out_active;

    modport master (output ioreq, rd, wr, a, d_in, input d_out, d_out_active);
    modport slave  (input ioreq, rd, wr, a, d_in, output d_out, d_out_active);
endinterface

// File: rtl/ulaplus_ext.sv
// ULA+ controller: CPU port decode, internal palette RAM with a pixel read port,
// auto-increment palette addressing and optionally frame-synchronous mode changes.
module ulaplus_ext #(
    parameter int  PAL_DEPTH  = 64,
    parameter int  COLOR_W    = 8,
    parameter int  DEFER_MODE = 1,
    localparam int IW         = $clog2(PAL_DEPTH)
) (
    input  logic               clk28,
    input  logic               rst_n,
    ulaplus_ext_if.slave       bus,
    input  logic               i_en,
    input  logic               i_magic_map,
    input  logic               i_frame_start,
    input  logic [IW-1:0]      i_pix_idx,
    output logic [COLOR_W-1:0] o_pix_color,
    output logic               o_active,
    output logic               o_autoinc,
    output logic [5:0]         o_timex_mode,
    output logic               o_suspend_multicolor
);

    logic [COLOR_W-1:0] r_pal [PAL_DEPTH];
    logic [COLOR_W-1:0] r_pix_color;
    logic [7:0]         r_addr;
    logic [7:0]         r_dout;
    logic [5:0]         r_pending;
    logic [5:0]         r_timex;
    logic               r_active;
    logic               r_autoinc;
    logic               r_susp;
    logic               r_wr_q;
    logic               r_rd_q;
    logic               r_dact;

    logic               w_cs_bf3b, w_cs_ff3b, w_cs_9ffd, w_cs_eff7, w_cs_ff;
    logic               w_wr_act, w_rd_act, w_wr_edge, w_rd_edge;
    logic               w_grp0, w_idx_ok, w_pal_we, w_inc;
    logic [IW-1:0]      w_pal_idx;
    logic [COLOR_W-1:0] w_pal_rd;
    logic [7:0]         w_d;
    logic [5:0]         w_pend_next;
    logic               w_mode_wr;

    assign w_d       = bus.d_in;
    assign w_cs_bf3b = bus.ioreq && (bus.a == 16'hBF3B) && i_en;
    assign w_cs_ff3b = bus.ioreq && (bus.a == 16'hFF3B) && i_en;
    assign w_cs_9ffd = bus.ioreq && (bus.a == 16'h9FFD);
    assign w_cs_eff7 = bus.ioreq && (bus.a == 16'hEFF7);
    assign w_cs_ff   = bus.ioreq && (bus.a[7:0] == 8'hFF) && !i_magic_map;

    // Each access acts once, on the rising edge of the qualified strobe.
    assign w_wr_act  = bus.wr && (w_cs_bf3b || w_cs_ff3b || w_cs_9ffd || w_cs_eff7 || w_cs_ff);
    assign w_rd_act  = bus.rd && (w_cs_ff3b || w_cs_9ffd);
    assign w_wr_edge = w_wr_act && !r_wr_q;
    assign w_rd_edge = w_rd_act && !r_rd_q;

    assign w_grp0    = (r_addr[7:6] == 2'b00);
    assign w_idx_ok  = w_grp0 && ((r_addr[5:0] >> IW) == 6'd0);
    assign w_pal_idx = r_addr[IW-1:0];
    assign w_pal_rd  = r_pal[w_pal_idx];
    assign w_pal_we  = w_wr_edge && w_cs_ff3b && w_idx_ok;
    assign w_inc     = w_grp0 && r_autoinc;

    // Next pending mode; exposed so a write coinciding with frame_start is applied at once.
    always_comb begin
        w_pend_next = r_pending;
        w_mode_wr   = 1'b0;
        if (w_wr_edge) begin
            if (w_cs_bf3b && (w_d[7:6] == 2'b01) && (w_d[5:0] != 6'd0)) begin
                w_pend_next = {w_d[5:3], w_d[1] & w_d[2], w_d[1], w_d[0] & ~w_d[1]};
                w_mode_wr   = 1'b1;
            end else if (w_cs_ff || w_cs_9ffd) begin
                w_pend_next = w_d[5:0];
                w_mode_wr   = 1'b1;
            end else if (w_cs_eff7 && w_d[0]) begin
                w_pend_next = 6'b111000;
                w_mode_wr   = 1'b1;
            end
        end
    end

    // Palette storage is not reset; contents are undefined after reset.
    always_ff @(posedge clk28) begin
        if (w_pal_we)
            r_pal[w_pal_idx] <= COLOR_W'(w_d);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n)
            r_pix_color <= '0;
        else
            r_pix_color <= r_pal[i_pix_idx];
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= 8'd0;
            r_dout    <= 8'd0;
            r_pending <= 6'd0;
            r_timex   <= 6'd0;
            r_active  <= 1'b0;
            r_autoinc <= 1'b0;
            r_susp    <= 1'b0;
            r_wr_q    <= 1'b0;
            r_rd_q    <= 1'b0;
            r_dact    <= 1'b0;
        end else begin
            r_wr_q    <= w_wr_act;
            r_rd_q    <= w_rd_act;
            r_pending <= w_pend_next;
            r_dact    <= w_rd_act && (r_dact || w_rd_edge);
            if (w_mode_wr)
                r_susp <= 1'b0;

            if (w_wr_edge && w_cs_bf3b)
                r_addr <= w_d;
            if (w_wr_edge && w_cs_ff3b) begin
                if (r_addr == 8'h40) begin
                    r_active  <= w_d[0];
                    r_autoinc <= w_d[1];
                    r_susp    <= ~r_active;
                end
                if (w_inc)
                    r_addr[5:0] <= r_addr[5:0] + 6'd1;
            end

            if (w_rd_edge) begin
                if (w_cs_ff3b) begin
                    if (w_idx_ok)
                        r_dout <= w_pal_rd[7:0];
                    else if (r_addr == 8'h40)
                        r_dout <= {6'b0, r_autoinc, r_active};
                    else
                        r_dout <= 8'h00;
                    if (w_inc)
                        r_addr[5:0] <= r_addr[5:0] + 6'd1;
                end else begin
                    r_dout <= {2'b00, r_pending};
                end
            end

            if (DEFER_MODE != 0) begin
                if (i_frame_start)
                    r_timex <= w_pend_next;
            end else begin
                r_timex <= r_pending;
            end

            if (!i_en)
                r_active <= 1'b0;
        end
    end

    assign o_pix_color          = r_pix_color;
    assign o_active             = r_active;
    assign o_autoinc            = r_autoinc;
    assign o_timex_mode         = r_timex;
    assign o_suspend_multicolor = r_susp;
    assign bus.d_out            = r_dout;
    assign bus.d_out_active     = r_dact;

endmodule

// File: tb/tb_ulaplus_ext.sv
// Directed bench: a 64-entry deferred-mode instance and a 16-entry immediate-mode
// instance share one CPU bus stimulus and are checked against hand-computed values.
module tb_ulaplus_ext;

    logic        clk28 = 1'b0;
    logic        rst_n;
    logic        ioreq, rd, wr, en, magic_map, frame_start;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [5:0]  pix;

    logic [7:0]  pix64, pix16;
    logic        act64, act16, ainc64, ainc16, susp64, susp16;
    logic [5:0]  tmx64, tmx16;

    int vectors = 0;
    int errors  = 0;

    ulaplus_ext_if bus64 ();
    ulaplus_ext_if bus16 ();

    assign bus64.ioreq = ioreq;
    assign bus64.rd    = rd;
    assign bus64.wr    = wr;
    assign bus64.a     = a;
    assign bus64.d_in  = d_in;
    assign bus16.ioreq = ioreq;
    assign bus16.rd    = rd;
    assign bus16.wr    = wr;
    assign bus16.a     = a;
    assign bus16.d_in  = d_in;

    ulaplus_ext #(.PAL_DEPTH(64), .COLOR_W(8), .DEFER_MODE(1)) u64 (
        .clk28(clk28), .rst_n(rst_n), .bus(bus64), .i_en(en), .i_magic_map(magic_map),
        .i_frame_start(frame_start), .i_pix_idx(pix), .o_pix_color(pix64),
        .o_active(act64), .o_autoinc(ainc64), .o_timex_mode(tmx64),
        .o_suspend_multicolor(susp64)
    );

    ulaplus_ext #(.PAL_DEPTH(16), .COLOR_W(8), .DEFER_MODE(0)) u16 (
        .clk28(clk28), .rst_n(rst_n), .bus(bus16), .i_en(en), .i_magic_map(magic_map),
        .i_frame_start(frame_start), .i_pix_idx(pix[3:0]), .o_pix_color(pix16),
        .o_active(act16), .o_autoinc(ainc16), .o_timex_mode(tmx16),
        .o_suspend_multicolor(susp16)
    );

    always #5 clk28 = ~clk28;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge of clk28.
    task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data, input int hold);
        ioreq = 1'b1; a = addr; d_in = data; wr = 1'b1;
        repeat (hold) @(negedge clk28);
        wr = 1'b0; ioreq = 1'b0;
        @(negedge clk28);
    endtask

    task automatic cpu_rd(input logic [15:0] addr, output logic [7:0] q64, output logic [7:0] q16,
                          output logic dact);
        ioreq = 1'b1; a = addr; rd = 1'b1;
        @(negedge clk28);
        q64  = bus64.d_out;
        q16  = bus16.d_out;
        dact = bus64.d_out_active;
        rd = 1'b0; ioreq = 1'b0;
        @(negedge clk28);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk28);
        frame_start = 1'b0;
    endtask

    initial begin
        logic [7:0] q64, q16;
        logic       dact;
        logic [7:0] exp_ent [4];
        exp_ent[0] = 8'h11; exp_ent[1] = 8'h22; exp_ent[2] = 8'h33; exp_ent[3] = 8'h44;

        rst_n = 1'b0; ioreq = 1'b0; rd = 1'b0; wr = 1'b0; a = 16'h0; d_in = 8'h0;
        en = 1'b1; magic_map = 1'b0; frame_start = 1'b0; pix = 6'd0;
        repeat (3) @(negedge clk28);
        chk("rst_pix", pix64, 8'h00);
        chk("rst_dout", bus64.d_out, 8'h00);
        rst_n = 1'b1;
        @(negedge clk28);
        chk("idle_active", act64, 1'b0);
        chk("idle_autoinc", ainc64, 1'b0);
        chk("idle_timex", tmx64, 6'h00);
        chk("idle_susp", susp64, 1'b0);
        chk("idle_dact", bus64.d_out_active, 1'b0);
        cpu_rd(16'h9FFD, q64, q16, dact);
        chk("9ffd_rst_rd", q64, 8'h00);
        chk("9ffd_rd_dact", dact, 1'b1);
        chk("dact_drop", bus64.d_out_active, 1'b0);

        // Enable palette mode with auto-increment, then fill entries 0..4.
        cpu_wr(16'hBF3B, 8'h40, 1);
        cpu_wr(16'hFF3B, 8'h03, 1);
        chk("en_active", act64, 1'b1);
        chk("en_autoinc", ainc64, 1'b1);
        chk("en_susp", susp64, 1'b1);
        chk("en_active16", act16, 1'b1);
        cpu_wr(16'hBF3B, 8'h00, 1);
        cpu_wr(16'hFF3B, 8'h11, 3);
        cpu_wr(16'hFF3B, 8'h22, 3);
        cpu_wr(16'hFF3B, 8'h33, 3);
        cpu_wr(16'hFF3B, 8'h44, 3);
        cpu_wr(16'hFF3B, 8'h55, 1);
        cpu_wr(16'hBF3B, 8'h40, 1);
        cpu_rd(16'hFF3B, q64, q16, dact);
        chk("reg40_rd", q64, 8'h03);
        cpu_wr(16'hBF3B, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            cpu_rd(16'hFF3B, q64, q16, dact);
            chk($sformatf("ent%0d_64", i), q64, exp_ent[i]);
            chk($sformatf("ent%0d_16", i), q16, exp_ent[i]);
        end
        cpu_wr(16'hBF3B, 8'h04, 1);
        cpu_rd(16'hFF3B, q64, q16, dact);
        chk("ent4_addr04", q64, 8'h55);

        // Auto-increment wraps over 6 bits; 0x3F is out of range for the 16-entry palette.
        cpu_wr(16'hBF3B, 8'h3F, 1);
        cpu_wr(16'hFF3B, 8'hAA, 1);
        cpu_wr(16'hFF3B, 8'hBB, 1);
        cpu_wr(16'hBF3B, 8'h3F, 1);
        cpu_rd(16'hFF3B, q64, q16, dact);
        chk("wrap_ent63", q64, 8'hAA);
        chk("wrap_ent63_16", q16, 8'h00);
        cpu_rd(16'hFF3B, q64, q16, dact);
        chk("wrap_ent0", q64, 8'hBB);
        chk("wrap_ent0_16", q16, 8'hBB);

        cpu_wr(16'hBF3B, 8'h20, 1);
        cpu_wr(16'hFF3B, 8'h77, 1);
        cpu_wr(16'hBF3B, 8'h20, 1);
        cpu_rd(16'hFF3B, q64, q16, dact);
        chk("idx20_64", q64, 8'h77);
        chk("idx20_16", q16, 8'h00);

        // Mode writes: deferred on the 64-entry instance, immediate on the 16-entry one.
        cpu_wr(16'h00FF, 8'h06, 1);
        chk("ff_defer_hold", tmx64, 6'h00);
        chk("ff_immediate", tmx16, 6'h06);
        chk("ff_susp_clr", susp64, 1'b0);
        repeat (3) @(negedge clk28);
        chk("ff_defer_still", tmx64, 6'h00);
        frame();
        chk("ff_frame_apply", tmx64, 6'h06);
        cpu_rd(16'h9FFD, q64, q16, dact);
        chk("9ffd_rd", q64, 8'h06);
        magic_map = 1'b1;
        cpu_wr(16'h00FF, 8'h15, 1);
        frame();
        chk("magic_block", tmx64, 6'h06);
        cpu_rd(16'h9FFD, q64, q16, dact);
        chk("magic_pending", q64, 8'h06);
        magic_map = 1'b0;

        ioreq = 1'b1; a = 16'h9FFD; d_in = 8'h2A; wr = 1'b1; frame_start = 1'b1;
        @(negedge clk28);
        wr = 1'b0; ioreq = 1'b0; frame_start = 1'b0;
        chk("same_cycle_fs", tmx64, 6'h2A);
        @(negedge clk28);
        cpu_wr(16'hEFF7, 8'h01, 1);
        frame();
        chk("eff7_mode", tmx64, 6'h38);
        cpu_wr(16'hBF3B, 8'h7F, 1);
        frame();
        chk("bf3b_mode_7f", tmx64, 6'h3E);
        chk("bf3b_mode_7f_16", tmx16, 6'h3E);
        cpu_wr(16'hBF3B, 8'h45, 1);
        chk("bf3b_mode_45_16", tmx16, 6'h01);
        chk("bf3b_mode_45_hold", tmx64, 6'h3E);

        // Pixel port read-before-write on a same-cycle CPU write to the same entry.
        cpu_wr(16'hBF3B, 8'h05, 1);
        cpu_wr(16'hFF3B, 8'h12, 1);
        pix = 6'd5;
        @(negedge clk28);
        chk("pix5_init", pix64, 8'h12);
        cpu_wr(16'hBF3B, 8'h05, 1);
        ioreq = 1'b1; a = 16'hFF3B; d_in = 8'h5A; wr = 1'b1;
        @(negedge clk28);
        chk("pix5_old", pix64, 8'h12);
        chk("pix5_old_16", pix16, 8'h12);
        wr = 1'b0; ioreq = 1'b0;
        @(negedge clk28);
        chk("pix5_new", pix64, 8'h5A);

        // Dropping enable clears active only.
        en = 1'b0;
        @(negedge clk28);
        chk("endrop_active", act64, 1'b0);
        chk("endrop_active16", act16, 1'b0);
        chk("endrop_timex", tmx64, 6'h3E);
        chk("endrop_pix", pix64, 8'h5A);
        chk("endrop_autoinc", ainc64, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
